// File: rtl/gray_bin_frame.sv
// Framed gray-to-binary pixel stage: fixed/inverted/band/line-hysteresis modes, 1-cycle latency.
// Optional macro GRAY_BIN_STAT_EN adds a per-frame count of output ones (ones_cnt/stat_vld).
module gray_bin_frame #(
    parameter int DW   = 8,
    parameter int COLS = 640,
    parameter int CW   = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] thr_lo,
    input  logic [DW-1:0] thr_hi,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          din_sop,
    input  logic          din_eop,
    output logic          dout,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          frm_err,
`ifdef GRAY_BIN_STAT_EN
    output logic [CW-1:0] ones_cnt,
    output logic          stat_vld,
`endif
    output logic          busy
);

    localparam int CNTW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CNTW-1:0] LAST_COL = CNTW'(COLS - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] col_q, col_d, col_cur;
    logic            hyst_q, hyst_d, hyst_cur;
    logic [1:0]      mode_q, mode_e;
    logic [DW-1:0]   lo_q, hi_q, lo_e, hi_e;
    logic            acc, res, last_col, err_d;
    logic            dout_q, vld_q, sop_q, eop_q, err_q;

    // The sop pixel sees live config and a fresh line; everything else uses the frame's latched copy.
    always_comb begin
        mode_e   = din_sop ? mode   : mode_q;
        lo_e     = din_sop ? thr_lo : lo_q;
        hi_e     = din_sop ? thr_hi : hi_q;
        col_cur  = din_sop ? '0     : col_q;
        hyst_cur = din_sop ? 1'b0   : hyst_q;
        last_col = (col_cur == LAST_COL);
        unique case (mode_e)
            2'd0:    res = (din >= lo_e);
            2'd1:    res = (din <  lo_e);
            2'd2:    res = (din >= lo_e) && (din <= hi_e);
            default: res = (din >= hi_e) || ((din >= lo_e) && hyst_cur);
        endcase
    end

    always_comb begin
        acc     = 1'b0;
        err_d   = 1'b0;
        state_d = state_q;
        col_d   = col_q;
        hyst_d  = hyst_q;
        if (din_vld) begin
            acc   = din_sop || (state_q == ACTIVE);
            err_d = (state_q == IDLE) ? !din_sop
                                      : (din_sop || (din_eop && !last_col));
        end
        if (acc) begin
            col_d   = last_col ? '0   : col_cur + 1'b1;
            hyst_d  = last_col ? 1'b0 : res;
            state_d = din_eop ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            hyst_q  <= 1'b0;
            mode_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            dout_q  <= 1'b0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            hyst_q  <= hyst_d;
            if (acc && din_sop) begin
                mode_q <= mode;
                lo_q   <= thr_lo;
                hi_q   <= thr_hi;
            end
            dout_q <= acc && res;
            vld_q  <= acc;
            sop_q  <= acc && din_sop;
            eop_q  <= acc && din_eop;
            err_q  <= err_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign dout_sop = sop_q;
    assign dout_eop = eop_q;
    assign frm_err  = err_q;
    assign busy     = (state_q == ACTIVE);

`ifdef GRAY_BIN_STAT_EN
    logic [CW-1:0] cnt_q, cnt_d, cnt_base, ones_q;
    logic          stat_q;

    always_comb begin
        cnt_base = (acc && din_sop) ? '0 : cnt_q;
        cnt_d    = (acc && res && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
    end

    // The reported total includes the eop pixel itself, hence cnt_d rather than cnt_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            ones_q <= '0;
            stat_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            stat_q <= acc && din_eop;
            if (acc && din_eop) ones_q <= cnt_d;
        end
    end

    assign ones_cnt = ones_q;
    assign stat_vld = stat_q;
`endif

endmodule

// File: doc/gray_bin_frame.md
Name: gray_bin_frame

Overview:
Parametrised pixel-stream binarizer and the successor to the single-threshold gray-to-bit stage in the edge-detection pipeline. It takes DW-bit gray pixels with vld/sop/eop framing and produces a 1-bit pixel stream with 1-cycle latency. It supports four run-time modes: fixed, inverted, band and line-hysteresis. Configuration is latched per frame, and a framing FSM flags protocol violations.

Parameters:
DW, 8, gray pixel width in bits
COLS, 640, valid pixels per line; hysteresis state clears at each line boundary
CW, 20, width of ones_cnt (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
mode  in  2  0 fixed, 1 inverted, 2 band, 3 hysteresis; sampled at frame start
thr_lo  in  DW  low threshold; sampled at frame start
thr_hi  in  DW  high threshold; sampled at frame start
din  in  DW  gray pixel
din_vld  in  1  pixel valid
din_sop  in  1  first pixel of frame; qualified by din_vld
din_eop  in  1  last pixel of frame; qualified by din_vld
dout  out  1  binary pixel
dout_vld  out  1  output valid
dout_sop  out  1  output frame start
dout_eop  out  1  output frame end
frm_err  out  1  1-cycle pulse on a framing violation
busy  out  1  1 while the FSM is in ACTIVE

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. Column counter, hysteresis flag and latched config are 0.
- Accepted pixel: din_vld=1 and the FSM admits it (see FSM).
- Accepted pixel at cycle N produces dout/dout_vld/dout_sop/dout_eop at cycle N+1. If no pixel is accepted, dout_vld=0 and dout, dout_sop, dout_eop are 0.
- Config latch: on an accepted sop, mode/thr_lo/thr_hi are registered. The sop pixel itself is evaluated with the live input values. Later pixels in the frame use the latched values, so input changes mid-frame have no effect.
- Decision per pixel, with comparisons unsigned and DW-bit:
  - mode 0: din>=thr_lo
  - mode 1: din<thr_lo
  - mode 2: thr_lo<=din<=thr_hi; if lo>hi, all pixels give 0
  - mode 3: din>=thr_hi, OR (din>=thr_lo AND hyst=1). hyst is set to the pixel's result after each pixel.
- Column counter: increments on each accepted pixel. When it reaches COLS-1 it wraps to 0 on the next accepted pixel. hyst is cleared at that wrap, so the first pixel of a line sees hyst=0.
- Both col and hyst are forced to 0 on an accepted sop, which starts col=1 after the sop pixel.
- FSM states: IDLE and ACTIVE.
  - IDLE, vld&sop&!eop: go to ACTIVE.
  - IDLE, vld&sop&eop: single-pixel frame; output it and stay in IDLE.
  - IDLE, vld&!sop: pixel is dropped (no dout_vld) and frm_err pulses.
  - ACTIVE, vld&eop&!sop: go to IDLE.
  - ACTIVE, vld&sop: frm_err pulses. The frame restarts: config is relatched, col and hyst clear, the pixel is output with dout_sop=1, and the FSM stays in ACTIVE (or goes to IDLE if eop is also set).
  - ACTIVE, eop with col != COLS-1 before the increment: pixel is output, frm_err pulses, FSM goes to IDLE.
- frm_err timing: aligned with the dout cycle of the offending pixel, i.e. N+1.
- busy is the registered FSM state.
- Reset mid-frame: all state and outputs clear immediately. The next frame needs a fresh sop.

Optional Feature:
Macro GRAY_BIN_STAT_EN.
- Defined: adds ports ones_cnt (out, CW) and stat_vld (out, 1).
  - An internal counter clears on accepted sop and increments for each output 1 in the frame, saturating at all-ones.
  - On the dout_eop cycle, stat_vld=1 and ones_cnt holds the total including the eop pixel.
  - ones_cnt holds that value until the next stat_vld. Reset value is 0.
- Undefined: ports, counter and logic are absent. All other behaviour is identical.

Test Plan:
- COLS=4, mode 0, thr_lo=100. One 4-pixel frame din=99,100,200,0 -> dout=0,1,1,0 one cycle later, dout_sop on pixel 1, dout_eop on pixel 4, frm_err=0.
- Mode 3, lo=50, hi=150, COLS=4. Line 60,160,60,40 then 60,60,160,60 -> line 1 gives 0,1,1,0; line 2 gives 0,0,1,1 (hyst cleared at the line wrap).
- Mode 2, lo=10, hi=20, with thr_hi changed to 5 mid-frame. Pixels 15,25 -> 1,0 using latched hi=20. Next frame with lo=10, hi=5 -> all 0.
- Framing errors:
  - vld without sop in IDLE -> no dout_vld, frm_err pulse.
  - sop at col 2 in ACTIVE -> frm_err pulse, dout_sop=1, frame restarts.
  - eop at col 1 -> frm_err, busy=0 next cycle.
- Assert rst during pixel 2 of a frame -> all outputs 0 next edge. Post-reset pixel without sop is dropped.
- GRAY_BIN_STAT_EN, mode 0, lo=128, 8-pixel frame with 5 pixels >=128 -> stat_vld with ones_cnt=5 on the dout_eop cycle. CW=2 with 5 ones -> saturates at 3.
